vapu_issuer: RTL and testbench

- CPU-side initiator for the accelerator's APU request/response interface.
- Accepts decoded vector-instruction fields, encodes them into a 32-bit RISC-V vector instruction word, and issues it with scalar operands over the APU handshake.
- Collects returned results into a credit-protected result FIFO.
- Used as the bring-up/traffic driver in front of the accelerator top level; the inverse of the accelerator's instruction decode.

---
 rtl/vapu_issuer.sv | 162 ++++++++++++++++
 tb/tb_vapu_issuer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vapu_issuer.sv
// APU request initiator: packs decoded vector-instruction fields into an RVV instruction word,
// issues it with scalar operands over the APU handshake and buffers results in a credit-guarded FIFO.
module vapu_issuer #(
   parameter int unsigned RESULT_DEPTH   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              cmd_valid_i,
   output logic                              cmd_ready_o,
   input  logic [1:0]                        cmd_major_i,
   input  logic [5:0]                        cmd_funct6_i,
   input  logic                              cmd_vm_i,
   input  logic [2:0]                        cmd_funct3_i,
   input  logic [4:0]                        cmd_vs2_i,
   input  logic [4:0]                        cmd_vs1_i,
   input  logic [4:0]                        cmd_vd_i,
   input  logic [10:0]                       cmd_zimm_i,
   input  logic [31:0]                       cmd_rs1_val_i,
   input  logic [31:0]                       cmd_rs2_val_i,
   output logic                              apu_req_o,
   input  logic                              apu_gnt_i,
   output logic [31:0]                       apu_op0_o,
   output logic [31:0]                       apu_op1_o,
   output logic [31:0]                       apu_op2_o,
   input  logic                              apu_rvalid_i,
   input  logic [31:0]                       apu_result_i,
   output logic                              res_valid_o,
   input  logic                              res_ready_i,
   output logic [31:0]                       res_data_o,
   output logic [$clog2(RESULT_DEPTH+1)-1:0] outstanding_o,
   output logic [1:0]                        err_o
);
   localparam int unsigned CntW = $clog2(RESULT_DEPTH + 1);
   localparam int unsigned PtrW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
   localparam int unsigned TotW = CntW + 2;
   localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] MajorLoadFp  = 2'd0;
   localparam logic [1:0] MajorStoreFp = 2'd1;
   localparam logic [1:0] MajorOpV     = 2'd2;
   localparam logic [2:0] Funct3OpCfg  = 3'b111;

   logic            req_q, req_d;
   logic [31:0]     op0_q, op1_q, op2_q;
   logic [CntW-1:0] out_q, out_d, cnt_q, cnt_d;
   logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [WdW-1:0]  wd_q, wd_d;
   logic [1:0]      err_q, err_d;
   logic [31:0]     mem_q [RESULT_DEPTH];

   logic [6:0]      opcode;
   logic [31:0]     insn;
   logic [TotW-1:0] total;
   logic            grant, rv_ok, rv_bad, pop, accept;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(RESULT_DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   always_comb begin
      case (cmd_major_i)
         MajorLoadFp:  opcode = 7'b0000111;
         MajorStoreFp: opcode = 7'b0100111;
         MajorOpV:     opcode = 7'b1010111;
         default:      opcode = 7'b0001011;
      endcase
      insn = {cmd_funct6_i, cmd_vm_i, cmd_vs2_i, cmd_vs1_i, cmd_funct3_i, cmd_vd_i, opcode};
      // vsetvli carries the vtype immediate where funct6/vm/vs2 would sit
      if (cmd_major_i == MajorOpV && cmd_funct3_i == Funct3OpCfg) begin
         insn[31:20] = {1'b0, cmd_zimm_i};
      end
   end

   assign grant       = req_q & apu_gnt_i;
   assign rv_ok       = apu_rvalid_i & ((out_q != '0) | grant);
   assign rv_bad      = apu_rvalid_i & ~rv_ok;
   assign pop         = (cnt_q != '0) & res_ready_i;
   assign total       = TotW'(req_q) + TotW'(out_q) + TotW'(cnt_q);
   assign cmd_ready_o = (~req_q | apu_gnt_i) & (total < TotW'(RESULT_DEPTH));
   assign accept      = cmd_valid_i & cmd_ready_o;

   always_comb begin
      req_d = req_q;
      if (accept) begin
         req_d = 1'b1;
      end else if (grant) begin
         req_d = 1'b0;
      end

      out_d = out_q;
      if (grant & ~rv_ok) begin
         out_d = out_q + CntW'(1);
      end else if (~grant & rv_ok) begin
         out_d = out_q - CntW'(1);
      end

      cnt_d = cnt_q;
      if (rv_ok & ~pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (~rv_ok & pop) begin
         cnt_d = cnt_q - CntW'(1);
      end

      wr_d = rv_ok ? ptr_inc(wr_q) : wr_q;
      rd_d = pop ? ptr_inc(rd_q) : rd_q;

      wd_d = wd_q;
      if (out_q == '0 || apu_rvalid_i) begin
         wd_d = '0;
      end else if (wd_q != WdW'(TIMEOUT_CYCLES)) begin
         wd_d = wd_q + WdW'(1);
      end

      err_d = err_q | {rv_bad, (wd_d == WdW'(TIMEOUT_CYCLES))};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= 1'b0;
         op0_q <= '0;
         op1_q <= '0;
         op2_q <= '0;
         out_q <= '0;
         cnt_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         wd_q  <= '0;
         err_q <= '0;
      end else begin
         req_q <= req_d;
         out_q <= out_d;
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         wd_q  <= wd_d;
         err_q <= err_d;
         if (accept) begin
            op0_q <= cmd_rs1_val_i;
            op1_q <= cmd_rs2_val_i;
            op2_q <= insn;
         end
      end
   end

   // Storage needs no reset: the read side is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rv_ok) begin
         mem_q[wr_q] <= apu_result_i;
      end
   end

   assign apu_req_o     = req_q;
   assign apu_op0_o     = op0_q;
   assign apu_op1_o     = op1_q;
   assign apu_op2_o     = op2_q;
   assign res_valid_o   = (cnt_q != '0);
   assign res_data_o    = res_valid_o ? mem_q[rd_q] : '0;
   assign outstanding_o = out_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_vapu_issuer.sv
// Directed bench for vapu_issuer: instruction and result scoreboards plus explicit timing checks.
module tb_vapu_issuer;
   localparam int unsigned Depth = 4;
   localparam int unsigned Tmo   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid_i, cmd_ready_o;
   logic [1:0]  cmd_major_i;
   logic [5:0]  cmd_funct6_i;
   logic        cmd_vm_i;
   logic [2:0]  cmd_funct3_i;
   logic [4:0]  cmd_vs2_i, cmd_vs1_i, cmd_vd_i;
   logic [10:0] cmd_zimm_i;
   logic [31:0] cmd_rs1_val_i, cmd_rs2_val_i;
   logic        apu_req_o, apu_gnt_i;
   logic [31:0] apu_op0_o, apu_op1_o, apu_op2_o;
   logic        apu_rvalid_i;
   logic [31:0] apu_result_i;
   logic        res_valid_o, res_ready_i;
   logic [31:0] res_data_o;
   logic [2:0]  outstanding_o;
   logic [1:0]  err_o;

   vapu_issuer #(.RESULT_DEPTH(Depth), .TIMEOUT_CYCLES(Tmo)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_major_i(cmd_major_i), .cmd_funct6_i(cmd_funct6_i), .cmd_vm_i(cmd_vm_i),
      .cmd_funct3_i(cmd_funct3_i), .cmd_vs2_i(cmd_vs2_i), .cmd_vs1_i(cmd_vs1_i),
      .cmd_vd_i(cmd_vd_i), .cmd_zimm_i(cmd_zimm_i),
      .cmd_rs1_val_i(cmd_rs1_val_i), .cmd_rs2_val_i(cmd_rs2_val_i),
      .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
      .apu_op0_o(apu_op0_o), .apu_op1_o(apu_op1_o), .apu_op2_o(apu_op2_o),
      .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
      .outstanding_o(outstanding_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] insn_q[$];
   logic [31:0] res_q[$];
   logic [31:0] held_op0, held_op1, held_op2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_model();
      logic [6:0]  opc;
      logic [11:0] hi;
      case (cmd_major_i)
         2'd0:    opc = 7'b0000111;
         2'd1:    opc = 7'b0100111;
         2'd2:    opc = 7'b1010111;
         default: opc = 7'b0001011;
      endcase
      hi = {cmd_funct6_i, cmd_vm_i, cmd_vs2_i};
      if (cmd_major_i == 2'd2 && cmd_funct3_i == 3'b111) hi = {1'b0, cmd_zimm_i};
      return {hi, cmd_vs1_i, cmd_funct3_i, cmd_vd_i, opc};
   endfunction

   task automatic cmd(input logic [1:0] mj, input logic [5:0] f6, input logic vm,
                      input logic [2:0] f3, input logic [4:0] vs2, input logic [4:0] vs1,
                      input logic [4:0] vd, input logic [10:0] zimm,
                      input logic [31:0] rs1, input logic [31:0] rs2);
      cmd_major_i = mj;  cmd_funct6_i = f6; cmd_vm_i = vm;   cmd_funct3_i = f3;
      cmd_vs2_i   = vs2; cmd_vs1_i    = vs1; cmd_vd_i = vd;  cmd_zimm_i   = zimm;
      cmd_rs1_val_i = rs1; cmd_rs2_val_i = rs2; cmd_valid_i = 1'b1;
   endtask

   // Samples handshakes just before the edge, scoreboards them, then advances one cycle.
   task automatic step();
      #1;
      if (apu_req_o && apu_gnt_i) begin
         check("insn_sb_nonempty", 32'(insn_q.size() > 0), 32'd1);
         if (insn_q.size() > 0) check("insn_sb", apu_op2_o, insn_q.pop_front());
      end
      if (cmd_valid_i && cmd_ready_o) insn_q.push_back(enc_model());
      if (res_valid_o && res_ready_i) begin
         check("res_sb_nonempty", 32'(res_q.size() > 0), 32'd1);
         if (res_q.size() > 0) check("res_sb", res_data_o, res_q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ret(input logic [31:0] data);
      apu_rvalid_i = 1'b1;
      apu_result_i = data;
      res_q.push_back(data);
      step();
      apu_rvalid_i = 1'b0;
   endtask

   task automatic drain();
      res_ready_i = 1'b1;
      for (int i = 0; i < 16 && res_q.size() > 0; i++) step();
      res_ready_i = 1'b0;
      check("drain_empty", 32'(res_q.size()), 32'd0);
      check("drain_valid", 32'(res_valid_o), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid_i = 1'b0; apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0; res_ready_i = 1'b0;
      apu_result_i = '0;
      cmd(2'd0, 6'd0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 11'd0, 32'd0, 32'd0);
      cmd_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", 32'(apu_req_o), 32'd0);
      check("rst_op2", apu_op2_o, 32'd0);
      check("rst_res_valid", 32'(res_valid_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_ready", 32'(cmd_ready_o), 32'd1);

      // vadd.vv encode, then a 3-cycle grant stall
      cmd(2'd2, 6'd0, 1'b1, 3'b000, 5'd2, 5'd3, 5'd1, 11'd0, 32'h1111_0000, 32'h2222_0000);
      step();
      cmd_valid_i = 1'b0;
      check("vadd_req", 32'(apu_req_o), 32'd1);
      check("vadd_insn", apu_op2_o, 32'h0221_80D7);
      held_op0 = apu_op0_o; held_op1 = apu_op1_o; held_op2 = apu_op2_o;
      check("vadd_op0", held_op0, 32'h1111_0000);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_req", 32'(apu_req_o), 32'd1);
         check("stall_op0", apu_op0_o, held_op0);
         check("stall_op1", apu_op1_o, held_op1);
         check("stall_op2", apu_op2_o, held_op2);
         check("stall_ready", 32'(cmd_ready_o), 32'd0);
      end

      // Grant with vsetvli waiting: back-to-back issue
      cmd(2'd2, 6'd0, 1'b0, 3'b111, 5'd0, 5'd10, 5'd5, 11'h008, 32'd16, 32'd0);
      apu_gnt_i = 1'b1;
      #1;
      check("b2b_ready", 32'(cmd_ready_o), 32'd1);
      step();
      cmd_valid_i = 1'b0;
      check("vset_req", 32'(apu_req_o), 32'd1);
      check("vset_insn", apu_op2_o, 32'h0085_72D7);
      check("vset_op0", apu_op0_o, 32'd16);
      check("vset_out", 32'(outstanding_o), 32'd1);
      step();
      apu_gnt_i = 1'b0;
      check("vset_req_drop", 32'(apu_req_o), 32'd0);
      check("out_two", 32'(outstanding_o), 32'd2);
      ret(32'hAAAA_0001);
      check("res_first", res_data_o, 32'hAAAA_0001);
      res_ready_i = 1'b1;
      ret(32'd16);
      res_ready_i = 1'b0;
      check("vset_result", res_data_o, 32'd16);
      check("out_zero", 32'(outstanding_o), 32'd0);
      drain();

      // Credit full with the result FIFO stalled
      apu_gnt_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cmd(2'(i), 6'(i + 1), 1'b1, 3'(i), 5'(i), 5'(i + 4), 5'(i + 8), 11'h0,
             32'(i), 32'(100 + i));
         #1;
         check("credit_ready", 32'(cmd_ready_o), 32'd1);
         step();
      end
      cmd_valid_i = 1'b0;
      #1;
      check("credit_block", 32'(cmd_ready_o), 32'd0);
      step();
      apu_gnt_i = 1'b0;
      check("credit_out4", 32'(outstanding_o), 32'd4);
      for (int i = 0; i < 4; i++) ret(32'h100 + 32'(i));
      check("full_out0", 32'(outstanding_o), 32'd0);
      check("full_ready", 32'(cmd_ready_o), 32'd0);
      res_ready_i = 1'b1;
      #1;
      check("pop_same_cycle", 32'(cmd_ready_o), 32'd0);
      step();
      res_ready_i = 1'b0;
      check("pop_frees", 32'(cmd_ready_o), 32'd1);

      // Watchdog: grant, then no rvalid
      cmd(2'd3, 6'h3F, 1'b0, 3'b101, 5'd31, 5'd17, 5'd9, 11'h7FF, 32'hCAFE, 32'hF00D);
      apu_gnt_i = 1'b1;
      step();
      cmd_valid_i = 1'b0;
      step();
      apu_gnt_i = 1'b0;
      check("wd_out1", 32'(outstanding_o), 32'd1);
      repeat (Tmo - 1) step();
      check("wd_before", 32'(err_o), 32'd0);
      step();
      check("wd_fire", 32'(err_o), 32'd1);
      ret(32'hBEEF_0005);
      check("wd_out0", 32'(outstanding_o), 32'd0);
      drain();

      // Spurious rvalid
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'hDEAD_DEAD;
      step();
      apu_rvalid_i = 1'b0;
      check("spur_err", 32'(err_o), 32'd3);
      check("spur_valid", 32'(res_valid_o), 32'd0);
      check("spur_out", 32'(outstanding_o), 32'd0);

      // Reset mid-operation: 2 outstanding, 1 buffered
      apu_gnt_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd(2'd2, 6'(i), 1'b1, 3'd0, 5'(i), 5'(i), 5'(i), 11'd0, 32'(i), 32'(i));
         step();
      end
      cmd_valid_i = 1'b0;
      step();
      apu_gnt_i = 1'b0;
      ret(32'h5555_0000);
      check("mid_out2", 32'(outstanding_o), 32'd2);
      check("mid_valid", 32'(res_valid_o), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_req", 32'(apu_req_o), 32'd0);
      check("mid_rst_op0", apu_op0_o, 32'd0);
      check("mid_rst_valid", 32'(res_valid_o), 32'd0);
      check("mid_rst_data", res_data_o, 32'd0);
      check("mid_rst_out", 32'(outstanding_o), 32'd0);
      check("mid_rst_err", 32'(err_o), 32'd0);
      insn_q.delete();
      res_q.delete();
      rst = 1'b0;
      apu_rvalid_i = 1'b1;
      apu_result_i = 32'h7777_7777;
      step();
      apu_rvalid_i = 1'b0;
      check("post_rst_err", 32'(err_o), 32'd2);
      check("post_rst_valid", 32'(res_valid_o), 32'd0);
      check("post_rst_out", 32'(outstanding_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
